kernel_host_bridge: RTL and testbench
=====================================

KERNEL_HOST_BRIDGE -- requirements
Module: kernel_host_bridge

Interface
REQ-001 SHALL have parameter DATA_WID, default 32, the width of the word and kernel data bus.
REQ-002 SHALL have parameter ADDR_WID, default 16, the local buffer index width (depth 2^ADDR_WID).
REQ-003 SHALL have parameter TIMEOUT, default 0, the maximum RUN cycles; 0 disables the timeout.
REQ-004 SHALL have clk, input, 1, clock; reset reset, asynchronous, active-high; clock clk.
REQ-005 SHALL have reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have start, input, 1, launch pulse, accepted only in IDLE/DONE/ERR.
REQ-007 SHALL have read_base/write_base, input, 64 each, host base addresses.
REQ-008 SHALL have num_words and stride, input, 64 each, the transfer length and address increment.
REQ-009 SHALL have rd_en, rd_ack, output, 1 each, read request and one-cycle word-accepted pulse.
REQ-010 SHALL have rd_addr, output, 64, and rd_ready, input, 1, the host read address and data-valid.
REQ-011 SHALL have rd_data, input, DATA_WID, host read word.
REQ-012 SHALL have wr_en, wr_ack, output, 1 each, write request and one-cycle word-taken pulse.
REQ-013 SHALL have wr_addr, output, 64, and wr_data, output, DATA_WID, plus wr_ready, input, 1.
REQ-014 SHALL have k_start, output, 1, one-cycle kernel start, and k_done, input, 1, kernel completion.
REQ-015 SHALL have k_addr0/k_addr1, input, ADDR_WID, plus k_ce0/k_we0/k_ce1/k_we1, input, 1, the kernel port controls.
REQ-016 SHALL have k_d0/k_d1, input, DATA_WID, and k_q0/k_q1, output, DATA_WID, the kernel write/read data.
REQ-017 SHALL have busy/done/error, output, 1 each, err_code, output, 2, and compute_cycles, output, 64.

Function
REQ-018 SHALL use states IDLE, LOAD, KSTART, RUN, STORE, DONE, ERR; busy=1 exactly in LOAD..STORE.
REQ-019 SHALL, on accepted start, latch all base/length/stride inputs; later input changes are ignored until the next start.
REQ-020 SHALL, on accepted start, go to ERR with err_code=1 if num_words==0 or num_words>2^ADDR_WID; otherwise go to LOAD.
REQ-021 SHALL, in LOAD, hold rd_en=1 with rd_addr=read_base+i*stride (mod 2^64), for i=0..N-1.
REQ-022 SHALL, in LOAD when rd_ready=1, store rd_data at buf[i], pulse rd_ack next cycle, and advance i.
REQ-023 SHALL, after the last word is stored, drop rd_en and go to KSTART; rd_ready while rd_en=0 is ignored.
REQ-024 SHALL, in KSTART, assert k_start for exactly one cycle, clear compute_cycles to 0, then go to RUN.
REQ-025 SHALL, in RUN, serve both kernel ports each cycle: ce&we writes d; ce&!we returns buf[addr] on q one cycle later (read latency 1).
REQ-026 SHALL, in RUN, return old data for a same-address read and write in one cycle, and port 1 SHALL win when both ports write one address.
REQ-027 SHALL ignore kernel port activity outside RUN, and k_q0/k_q1 SHALL hold their last value.
REQ-028 SHALL, in RUN, increment compute_cycles every cycle, saturating at 2^64-1, and go to STORE on k_done.
REQ-029 SHALL, if TIMEOUT!=0 and compute_cycles reaches TIMEOUT before k_done, go to ERR with err_code=2; k_done in that same cycle wins.
REQ-030 SHALL, in STORE, hold wr_en=1 with wr_addr=write_base+j*stride and wr_data=buf[j] valid whenever wr_en=1.
REQ-031 SHALL, in STORE on wr_ready, pulse wr_ack for one cycle and present word j+1 on the following cycle.
REQ-032 SHALL, after the last word, drop wr_en and go to DONE.
REQ-033 SHALL hold done=1 in DONE and error=1 with err_code in ERR until the next accepted start or reset.
REQ-034 SHALL have start in DONE/ERR clear done/error/err_code and relaunch per REQ-020; start while busy is ignored.

Reset
REQ-035 SHALL, on reset (any state), give all outputs 0, set state to IDLE and zero counters; buffer contents are not cleared.
REQ-036 SHALL, on reset release, not move any state until a new start.

Verification
REQ-037 SHALL cover: N=4, stride=4, read_base=0x100, identity kernel (k_done 3 cycles after k_start) -> rd_addr 0x100/104/108/10C, writes to write_base+0..C with same data, done=1, compute_cycles=3.
REQ-038 SHALL cover: num_words=0 and num_words=2^ADDR_WID+1 -> ERR, err_code=1, no rd_en.
REQ-039 SHALL cover: TIMEOUT=10, kernel never done -> error=1, err_code=2 after 10 RUN cycles; then start -> LOAD.
REQ-040 SHALL cover: both ports write addr 5 (d0=0xA, d1=0xB) -> buf[5]=0xB on writeback; same-cycle read of addr 5 returns the old value.
REQ-041 SHALL cover: rd_ready/wr_ready stalls of 0-3 random cycles -> identical data and address sequence, one rd_ack/wr_ack per word.
REQ-042 SHALL cover: reset asserted mid-STORE -> outputs 0 immediately, IDLE; a following start completes correctly.

Source files
------------

// File: rtl/kernel_host_bridge.sv
// Host bridge: loads N words into a local buffer, starts a kernel on two ports,
// then writes the buffer back to the host, reporting done/error and cycle counts.
module kernel_host_bridge #(
  parameter int unsigned DATA_WID = 32,
  parameter int unsigned ADDR_WID = 16,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic [63:0]         num_words,
  input  logic [63:0]         stride,
  output logic                rd_en,
  output logic                rd_ack,
  output logic [63:0]         rd_addr,
  input  logic                rd_ready,
  input  logic [DATA_WID-1:0] rd_data,
  output logic                wr_en,
  output logic                wr_ack,
  output logic [63:0]         wr_addr,
  output logic [DATA_WID-1:0] wr_data,
  input  logic                wr_ready,
  output logic                k_start,
  input  logic                k_done,
  input  logic [ADDR_WID-1:0] k_addr0,
  input  logic [ADDR_WID-1:0] k_addr1,
  input  logic                k_ce0,
  input  logic                k_we0,
  input  logic                k_ce1,
  input  logic                k_we1,
  input  logic [DATA_WID-1:0] k_d0,
  input  logic [DATA_WID-1:0] k_d1,
  output logic [DATA_WID-1:0] k_q0,
  output logic [DATA_WID-1:0] k_q1,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [63:0]         compute_cycles
);

  localparam logic [63:0] DEPTH = 64'd1 << ADDR_WID;
  localparam logic [63:0] TMO   = 64'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KSTART, S_RUN, S_STORE, S_DONE, S_ERR
  } state_t;

  state_t              r_state, w_next;
  logic [63:0]         r_rd_addr, r_wr_addr, r_stride, r_cc;
  logic [ADDR_WID-1:0] r_idx, r_last;
  logic [1:0]          r_err_code;
  logic                r_rd_ack, r_wr_ack;
  logic [DATA_WID-1:0] r_q0, r_q1;
  logic [DATA_WID-1:0] r_buf [2**ADDR_WID];

  logic        w_accept, w_bad, w_last, w_rd_hs, w_wr_hs, w_timeout;
  logic [63:0] w_cc_next;

  assign w_accept  = (r_state inside {S_IDLE, S_DONE, S_ERR}) && start;
  assign w_bad     = (num_words == '0) || (num_words > DEPTH);
  assign w_last    = (r_idx == r_last);
  assign w_rd_hs   = (r_state == S_LOAD) && rd_ready;
  assign w_wr_hs   = (r_state == S_STORE) && wr_ready;
  assign w_cc_next = (r_cc == '1) ? r_cc : r_cc + 64'd1;
  assign w_timeout = (TMO != '0) && (w_cc_next >= TMO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = w_bad ? S_ERR : S_LOAD;
      S_LOAD:   if (rd_ready && w_last) w_next = S_KSTART;
      S_KSTART: w_next = S_RUN;
      // k_done takes priority over a timeout landing in the same cycle
      S_RUN: begin
        if (k_done)         w_next = S_STORE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_STORE:  if (wr_ready && w_last) w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    k_start = 1'b0;
    unique case (r_state)
      S_LOAD:   begin busy = 1'b1; rd_en = 1'b1; end
      S_KSTART: begin busy = 1'b1; k_start = 1'b1; end
      S_RUN:    busy = 1'b1;
      S_STORE:  begin busy = 1'b1; wr_en = 1'b1; end
      S_DONE:   done = 1'b1;
      S_ERR:    error = 1'b1;
      default:  ;
    endcase
    rd_addr = (r_state == S_LOAD)  ? r_rd_addr    : '0;
    wr_addr = (r_state == S_STORE) ? r_wr_addr    : '0;
    wr_data = (r_state == S_STORE) ? r_buf[r_idx] : '0;
  end

  assign rd_ack         = r_rd_ack;
  assign wr_ack         = r_wr_ack;
  assign err_code       = r_err_code;
  assign compute_cycles = r_cc;
  assign k_q0           = r_q0;
  assign k_q1           = r_q1;

  // r_idx is shared: it walks the buffer in LOAD, is rewound, then walks it again in STORE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_stride   <= '0;
      r_cc       <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_err_code <= '0;
      r_rd_ack   <= 1'b0;
      r_wr_ack   <= 1'b0;
    end else begin
      r_rd_ack <= w_rd_hs;
      r_wr_ack <= w_wr_hs;
      if (w_accept) begin
        r_rd_addr  <= read_base;
        r_wr_addr  <= write_base;
        r_stride   <= stride;
        r_last     <= ADDR_WID'(num_words - 64'd1);
        r_idx      <= '0;
        r_err_code <= w_bad ? 2'd1 : 2'd0;
      end
      if (w_rd_hs) begin
        r_rd_addr <= r_rd_addr + r_stride;
        r_idx     <= w_last ? '0 : r_idx + ADDR_WID'(1);
      end
      if (r_state == S_KSTART) r_cc <= '0;
      if (r_state == S_RUN) begin
        r_cc <= w_cc_next;
        if (!k_done && w_timeout) r_err_code <= 2'd2;
      end
      if (w_wr_hs) begin
        r_wr_addr <= r_wr_addr + r_stride;
        r_idx     <= w_last ? '0 : r_idx + ADDR_WID'(1);
      end
    end
  end

  // Port 1 is written after port 0 so it wins on an address collision
  always_ff @(posedge clk) begin
    if (w_rd_hs) r_buf[r_idx] <= rd_data;
    if (r_state == S_RUN) begin
      if (k_ce0 && k_we0) r_buf[k_addr0] <= k_d0;
      if (k_ce1 && k_we1) r_buf[k_addr1] <= k_d1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q0 <= '0;
      r_q1 <= '0;
    end else if (r_state == S_RUN) begin
      if (k_ce0 && !k_we0) r_q0 <= r_buf[k_addr0];
      if (k_ce1 && !k_we1) r_q1 <= r_buf[k_addr1];
    end
  end

endmodule

// File: tb/tb_kernel_host_bridge.sv
// Self-checking bench for kernel_host_bridge: job table plus hand-written
// kernel-port, timeout and mid-STORE reset sequences; host side is a scoreboard.
module tb_kernel_host_bridge;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [63:0]   read_base, write_base, num_words, stride;
  logic          rd_en, rd_ack, rd_ready;
  logic [63:0]   rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en, wr_ack, wr_ready;
  logic [63:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          k_start, k_done;
  logic [AW-1:0] k_addr0, k_addr1;
  logic          k_ce0, k_we0, k_ce1, k_we1;
  logic [DW-1:0] k_d0, k_d1, k_q0, k_q1;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [63:0]   compute_cycles;

  always #5 clk = ~clk;

  kernel_host_bridge #(.DATA_WID(DW), .ADDR_WID(AW), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .start(start),
    .read_base(read_base), .write_base(write_base), .num_words(num_words), .stride(stride),
    .rd_en(rd_en), .rd_ack(rd_ack), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_en(wr_en), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .k_start(k_start), .k_done(k_done),
    .k_addr0(k_addr0), .k_addr1(k_addr1),
    .k_ce0(k_ce0), .k_we0(k_we0), .k_ce1(k_ce1), .k_we1(k_we1),
    .k_d0(k_d0), .k_d1(k_d1), .k_q0(k_q0), .k_q1(k_q1),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .compute_cycles(compute_cycles)
  );

  typedef struct {
    logic [63:0] rb, wb, n, stride;
    bit          stall;
    logic [1:0]  exp_code;
  } job_t;

  typedef struct {
    logic [63:0]   a;
    logic [DW-1:0] d;
  } wexp_t;

  logic [63:0]   exp_rd_q[$];
  logic [DW-1:0] rd_dq[$];
  wexp_t         exp_wr_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit stall_en = 1'b0;
  int rd_stall = 0;
  int wr_stall = 0;
  bit rd_hs_last = 1'b0;
  bit wr_hs_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event, expected one within the cycle bound", name);
  endtask

  // Host read side: random stalls, checks each accepted address, supplies data
  initial begin
    rd_ready = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_hs_last = 1'b0;
        rd_ready   = 1'b0;
        continue;
      end
      if (rd_ack || rd_hs_last) chk("rd_ack", rd_ack, rd_hs_last);
      rd_hs_last = 1'b0;
      if (rd_en) begin
        rd_ready = 1'b0;
        if (rd_stall > 0) rd_stall--;
        else begin
          if (exp_rd_q.size() == 0) fail_now("rd_unexpected");
          else begin
            chk("rd_addr", rd_addr, exp_rd_q.pop_front());
            rd_data = (rd_dq.size() != 0) ? rd_dq.pop_front() : '0;
          end
          rd_ready   = 1'b1;
          rd_hs_last = 1'b1;
          rd_stall   = stall_en ? int'($urandom_range(0, 3)) : 0;
        end
      end else begin
        rd_ready = stall_en && ($urandom_range(0, 1) == 1);
        rd_data  = $urandom;
      end
    end
  end

  // Host write side: random stalls, checks address/data against the scoreboard
  initial begin
    wexp_t w;
    wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wr_hs_last = 1'b0;
        wr_ready   = 1'b0;
        continue;
      end
      if (wr_ack || wr_hs_last) chk("wr_ack", wr_ack, wr_hs_last);
      wr_hs_last = 1'b0;
      if (wr_en) begin
        wr_ready = 1'b0;
        if (wr_stall > 0) wr_stall--;
        else begin
          if (exp_wr_q.size() == 0) fail_now("wr_unexpected");
          else begin
            w = exp_wr_q.pop_front();
            chk("wr_addr", wr_addr, w.a);
            chk("wr_data", 64'(wr_data), 64'(w.d));
          end
          wr_ready   = 1'b1;
          wr_hs_last = 1'b1;
          wr_stall   = stall_en ? int'($urandom_range(0, 3)) : 0;
        end
      end else begin
        wr_ready = stall_en && ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected one within 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic kernel_idle();
    k_ce0 = 1'b0; k_we0 = 1'b0; k_ce1 = 1'b0; k_we1 = 1'b0;
    k_addr0 = '0; k_addr1 = '0; k_d0 = '0; k_d1 = '0;
  endtask

  // kmode: 0 identity kernel, 1 port collision kernel, 2 never done, 3 reset mid-STORE
  task automatic run_job(input job_t j, input int kmode);
    logic [DW-1:0] src [16];
    logic [DW-1:0] eb  [16];
    wexp_t w;
    bit found;
    stall_en = j.stall;
    if (j.exp_code == 2'd0) begin
      for (int i = 0; i < int'(j.n); i++) begin
        src[i] = $urandom;
        eb[i]  = src[i];
        exp_rd_q.push_back(j.rb + 64'(i) * j.stride);
        rd_dq.push_back(src[i]);
      end
      if (kmode == 1) eb[5] = 32'hB;
      if (kmode != 2)
        for (int i = 0; i < int'(j.n); i++) begin
          w.a = j.wb + 64'(i) * j.stride;
          w.d = eb[i];
          exp_wr_q.push_back(w);
        end
    end
    @(negedge clk);
    start = 1'b1; read_base = j.rb; write_base = j.wb; num_words = j.n; stride = j.stride;
    @(negedge clk);
    start = 1'b0; read_base = '1; write_base = 64'hBAD0; num_words = 64'd2; stride = 64'd1;
    if (j.exp_code == 2'd1) begin
      chk("badn_error", error, 1);
      chk("badn_code", err_code, 1);
      chk("badn_busy", busy, 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("badn_rd_en", rd_en, 0);
      end
      return;
    end
    chk("launch_busy", busy, 1);
    chk("launch_error", error, 0);
    chk("launch_done", done, 0);
    chk("launch_code", err_code, 0);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (k_start) found = 1'b1;
    end
    if (!found) begin
      fail_now("k_start_wait");
      exp_rd_q.delete(); rd_dq.delete(); exp_wr_q.delete();
      return;
    end
    @(negedge clk);
    chk("k_start_pulse", k_start, 0);
    chk("cc_cleared", compute_cycles, 0);
    if (kmode == 2) begin
      for (int c = 2; c <= 10; c++) begin
        @(negedge clk);
        if (c == 10) begin
          chk("tmo_still_busy", busy, 1);
          chk("tmo_not_yet", error, 0);
        end
      end
      @(negedge clk);
      chk("tmo_error", error, 1);
      chk("tmo_code", err_code, 2);
      chk("tmo_cycles", compute_cycles, 10);
      chk("tmo_busy", busy, 0);
      return;
    end
    if (kmode == 1) begin
      k_ce0 = 1'b1; k_we0 = 1'b0; k_addr0 = 4'd5;
      k_ce1 = 1'b1; k_we1 = 1'b1; k_addr1 = 4'd5; k_d1 = 32'hD;
      @(negedge clk);
      chk("q0_old_on_collide", 64'(k_q0), 64'(src[5]));
      k_we0 = 1'b1; k_d0 = 32'hA; k_d1 = 32'hB;
      @(negedge clk);
      k_we0 = 1'b0; k_we1 = 1'b0; k_addr1 = 4'd2; k_done = 1'b1;
      @(negedge clk);
      k_done = 1'b0;
      chk("q0_port1_wins", 64'(k_q0), 64'hB);
      chk("q1_read", 64'(k_q1), 64'(src[2]));
      k_we0 = 1'b1; k_d0 = 32'hFF; k_addr1 = 4'd3;
    end else begin
      start = 1'b1; num_words = '0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      k_done = 1'b1;
      @(negedge clk);
      k_done = 1'b0;
    end
    if (kmode == 3) begin
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", 64'(wr_data), 0);
      chk("rst_busy", busy, 0);
      chk("rst_cycles", compute_cycles, 0);
      chk("rst_q0", 64'(k_q0), 0);
      chk("rst_q1", 64'(k_q1), 0);
      chk("rst_rd_ack", rd_ack, 0);
      chk("rst_wr_ack", wr_ack, 0);
      exp_wr_q.delete();
      repeat (3) @(negedge clk);
      #3 reset = 1'b0;
      rd_stall = 0; wr_stall = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("post_rst_idle", {busy, done, error, rd_en}, 0);
      end
      return;
    end
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (done || error) found = 1'b1;
    end
    kernel_idle();
    if (!found) begin
      fail_now("done_wait");
      exp_rd_q.delete(); rd_dq.delete(); exp_wr_q.delete();
      return;
    end
    chk("done", done, 1);
    chk("done_error", error, 0);
    chk("done_busy", busy, 0);
    chk("compute_cycles", compute_cycles, 3);
    chk("rd_words_left", 64'(exp_rd_q.size()), 0);
    chk("wr_words_left", 64'(exp_wr_q.size()), 0);
    if (kmode == 1) begin
      chk("q0_hold", 64'(k_q0), 64'hB);
      chk("q1_hold", 64'(k_q1), 64'(src[2]));
    end
  endtask

  initial begin
    job_t jobs [6];
    job_t pj, tj, rj, fj;
    jobs[0] = '{64'h100, 64'h2000, 64'd4, 64'd4, 1'b0, 2'd0};
    jobs[1] = '{64'h100, 64'h2000, 64'd0, 64'd4, 1'b0, 2'd1};
    jobs[2] = '{64'h100, 64'h2000, 64'd17, 64'd4, 1'b0, 2'd1};
    jobs[3] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h40, 64'd16, 64'd8, 1'b1, 2'd0};
    jobs[4] = '{64'h1000, 64'h3000, 64'd1, 64'h10, 1'b1, 2'd0};
    jobs[5] = '{64'h55, 64'h77, 64'd7, 64'd3, 1'b1, 2'd0};
    pj = '{64'h8000, 64'h9000, 64'd8, 64'd4, 1'b1, 2'd0};
    tj = '{64'h400, 64'h500, 64'd2, 64'd4, 1'b0, 2'd0};
    rj = '{64'hA00, 64'hB00, 64'd8, 64'd4, 1'b1, 2'd0};
    fj = '{64'hC00, 64'hD00, 64'd5, 64'd8, 1'b1, 2'd0};

    reset = 1'b1; start = 1'b0; k_done = 1'b0;
    read_base = '0; write_base = '0; num_words = '0; stride = '0;
    kernel_idle();
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_code", err_code, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_k_start", k_start, 0);
    chk("reset_cycles", compute_cycles, 0);
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {busy, done, error}, 0);

    for (int i = 0; i < 6; i++) run_job(jobs[i], 0);
    run_job(pj, 1);
    run_job(tj, 2);
    run_job(jobs[0], 0);
    run_job(rj, 3);
    run_job(fj, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
